cordic_shift_sequencer: RTL and testbench



---
 rtl/cordic_shift_sequencer.sv | 153 +++++++++++++++
 tb/tb_cordic_shift_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_shift_sequencer.sv
// CORDIC iteration sequencer: shares one external barrel shifter between
// the y and x operands on alternate cycles and walks the atan table.
module cordic_shift_sequencer #(
  parameter int ITERATIONS = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [63:0] x_in,
  input  logic [63:0] y_in,
  input  logic [63:0] z_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] x_out,
  output logic [63:0] y_out,
  output logic [63:0] z_out,
  output logic [63:0] sh_data,
  output logic [5:0]  sh_amount,
  output logic        sh_dir,
  output logic        sh_arith,
  input  logic [63:0] sh_result,
  output logic [5:0]  atan_addr,
  input  logic [63:0] atan_data
);

  localparam logic [5:0] LAST = 6'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHY,
    SHX,
    FIN
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic        mode_q, mode_d;
  logic [63:0] x_q, x_d;
  logic [63:0] y_q, y_d;
  logic [63:0] z_q, z_d;
  logic [63:0] ysh_q, ysh_d;
  logic [63:0] xo_q, xo_d;
  logic [63:0] yo_q, yo_d;
  logic [63:0] zo_q, zo_d;
  logic        d_pos;

  // Rotation steers z toward 0, vectoring steers y toward 0.
  assign d_pos = mode_q ? y_q[63] : ~z_q[63];

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    mode_d    = mode_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    ysh_d     = ysh_q;
    xo_d      = xo_q;
    yo_d      = yo_q;
    zo_d      = zo_q;
    busy      = 1'b0;
    done      = 1'b0;
    sh_data   = '0;
    sh_amount = '0;
    sh_dir    = 1'b0;
    sh_arith  = 1'b0;
    atan_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          mode_d  = mode;
          i_d     = '0;
          state_d = SHY;
        end
      end
      SHY: begin
        busy      = 1'b1;
        sh_dir    = 1'b1;
        sh_arith  = 1'b1;
        sh_data   = y_q;
        sh_amount = i_q;
        ysh_d     = sh_result;
        state_d   = SHX;
      end
      SHX: begin
        busy      = 1'b1;
        sh_dir    = 1'b1;
        sh_arith  = 1'b1;
        sh_data   = x_q;
        sh_amount = i_q;
        atan_addr = i_q;
        if (d_pos) begin
          x_d = x_q - ysh_q;
          y_d = y_q + sh_result;
          z_d = z_q - atan_data;
        end else begin
          x_d = x_q + ysh_q;
          y_d = y_q - sh_result;
          z_d = z_q + atan_data;
        end
        if (i_q == LAST) begin
          state_d = FIN;
        end else begin
          i_d     = i_q + 6'd1;
          state_d = SHY;
        end
      end
      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        xo_d    = x_q;
        yo_d    = y_q;
        zo_d    = z_q;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ysh_q   <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      ysh_q   <= ysh_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

  assign x_out = xo_q;
  assign y_out = yo_q;
  assign z_out = zo_q;

endmodule

// File: tb/tb_cordic_shift_sequencer.sv
// Bench for cordic_shift_sequencer: default-depth and single-iteration
// instances, shifter/atan models, and a result scoreboard.
module tb_cordic_shift_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        mode;
  logic [63:0] x_in, y_in, z_in;
  logic        busy, done;
  logic [63:0] x_out, y_out, z_out;
  logic [63:0] sh_data, sh_result, atan_data;
  logic [5:0]  sh_amount, atan_addr;
  logic        sh_dir, sh_arith;

  logic        a_start;
  logic        a_busy, a_done;
  logic [63:0] a_x_out, a_y_out, a_z_out;
  logic [63:0] a_sh_data, a_sh_result, a_atan_data;
  logic [5:0]  a_sh_amount, a_atan_addr;
  logic        a_sh_dir, a_sh_arith;

  logic [63:0] atan_tab [64];

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] z;
  } res_t;
  res_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit pend = 0;

  cordic_shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .sh_data(sh_data), .sh_amount(sh_amount),
    .sh_dir(sh_dir), .sh_arith(sh_arith), .sh_result(sh_result),
    .atan_addr(atan_addr), .atan_data(atan_data)
  );

  cordic_shift_sequencer #(.ITERATIONS(1)) dut1 (
    .clk(clk), .reset(reset), .start(a_start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(a_busy), .done(a_done),
    .x_out(a_x_out), .y_out(a_y_out), .z_out(a_z_out),
    .sh_data(a_sh_data), .sh_amount(a_sh_amount),
    .sh_dir(a_sh_dir), .sh_arith(a_sh_arith), .sh_result(a_sh_result),
    .atan_addr(a_atan_addr), .atan_data(a_atan_data)
  );

  assign sh_result = sh_dir ?
    (sh_arith ? 64'($signed(sh_data) >>> sh_amount) : sh_data >> sh_amount) :
    sh_data << sh_amount;
  assign a_sh_result = a_sh_dir ?
    (a_sh_arith ? 64'($signed(a_sh_data) >>> a_sh_amount) :
     a_sh_data >> a_sh_amount) :
    a_sh_data << a_sh_amount;
  assign atan_data   = atan_tab[atan_addr];
  assign a_atan_data = (a_atan_addr == 6'd0) ? 64'h10 : 64'h0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [63:0] xi, yi, zi,
                                input logic md, input int n,
                                output logic [63:0] xo, yo, zo);
    logic [63:0] x, y, z, xs, ys;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < n; i++) begin
      ys = 64'($signed(y) >>> i);
      xs = 64'($signed(x) >>> i);
      if (md ? y[63] : !z[63]) begin
        x = x - ys; y = y + xs; z = z - atan_tab[i];
      end else begin
        x = x + ys; y = y - xs; z = z + atan_tab[i];
      end
    end
    xo = x; yo = y; zo = z;
  endfunction

  // Scoreboard: results checked the cycle after the done pulse.
  always @(negedge clk) begin
    res_t e;
    if (pend) begin
      pend = 0;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_x", x_out, e.x);
        chk("sb_y", y_out, e.y);
        chk("sb_z", z_out, e.z);
      end
    end
    if (done) begin
      done_cnt++;
      pend = 1;
    end
  end

  task automatic drive_push(input logic md, input logic [63:0] xv, yv, zv);
    res_t e;
    mode = md; x_in = xv; y_in = yv; z_in = zv;
    model(xv, yv, zv, md, 48, e.x, e.y, e.z);
    exp_q.push_back(e);
  endtask

  task automatic launch(input logic md, input logic [63:0] xv, yv, zv);
    @(negedge clk);
    drive_push(md, xv, yv, zv);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int c0, input int limit, output int cyc);
    cyc = c0;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int c, c2, dc;
    logic [63:0] mx, my, mz, xs, ys;
    longint ly, lz, lx, ez, ex;
    real kg;

    for (int i = 0; i < 64; i++)
      atan_tab[i] = 64'(longint'($atan(2.0 ** (-i)) * (2.0 ** 61)));
    reset = 1; start = 0; a_start = 0; mode = 0;
    x_in = '0; y_in = '0; z_in = '0;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_main", {busy, done, x_out, y_out, z_out, sh_amount, sh_dir},
        '0);
    chk("rst_n1", {a_busy, a_done, a_x_out, a_sh_amount, a_sh_dir}, '0);
    reset = 0;

    // ITERATIONS=1 rotation
    @(negedge clk);
    mode = 0; x_in = 64'h100; y_in = 0; z_in = 0; a_start = 1;
    @(negedge clk);
    a_start = 0;
    chk("n1_shy", {a_busy, a_done, a_sh_amount, a_sh_dir, a_sh_arith,
        a_sh_data}, {1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 64'h0});
    @(negedge clk);
    chk("n1_shx", {a_busy, a_done, a_sh_amount, a_atan_addr, a_sh_data},
        {1'b1, 1'b0, 6'd0, 6'd0, 64'h100});
    @(negedge clk);
    chk("n1_done_c3", {a_busy, a_done}, 2'b11);
    @(negedge clk);
    chk("n1_idle", {a_busy, a_done}, 2'b00);
    chk("n1_x", a_x_out, 64'h100);
    chk("n1_y", a_y_out, 64'h100);
    chk("n1_z", a_z_out, 64'hFFFF_FFFF_FFFF_FFF0);

    // Shifter port sequence, default depth
    mx = 64'h0123_4567_89AB_CDEF;
    my = 64'hFF00_0000_0000_1234;
    mz = 64'hF000_0000_0000_0000;
    launch(0, mx, my, mz);
    ys = '0;
    for (int k = 1; k <= 96; k++) begin
      int i;
      i = (k - 1) / 2;
      if (k % 2 == 1) begin
        chk($sformatf("shy_c%0d", k),
            {sh_data, sh_amount, sh_dir, sh_arith, busy, done},
            {my, 6'(i), 4'b1110});
        ys = 64'($signed(my) >>> i);
      end else begin
        chk($sformatf("shx_c%0d", k),
            {sh_data, sh_amount, atan_addr, sh_dir, sh_arith, busy, done},
            {mx, 6'(i), 6'(i), 4'b1110});
        xs = 64'($signed(mx) >>> i);
        if (!mz[63]) begin
          mx = mx - ys; my = my + xs; mz = mz - atan_tab[i];
        end else begin
          mx = mx + ys; my = my - xs; mz = mz + atan_tab[i];
        end
      end
      @(negedge clk);
    end
    chk("done_c97", {busy, done}, 2'b11);
    @(negedge clk);
    chk("idle_after_fin", {busy, done, sh_amount, sh_dir}, '0);

    // Vectoring convergence
    launch(1, 64'h1000_0000_0000_0000, 64'h1000_0000_0000_0000, 0);
    wait_done(1, 200, c);
    chk("vec_latency", c, 97);
    @(negedge clk);
    kg = 1.0;
    for (int i = 0; i < 48; i++) kg = kg * $sqrt(1.0 + 2.0 ** (-2 * i));
    ly = $signed(y_out);
    lz = $signed(z_out);
    lx = $signed(x_out);
    ez = longint'(3.14159265358979 / 4.0 * (2.0 ** 61));
    ex = longint'(kg * $sqrt(2.0) * (2.0 ** 60));
    chk("vec_y_small", (ly < 65536 && ly > -65536), 1);
    chk("vec_z_pi4", (lz - ez < 65536 && ez - lz < 65536), 1);
    chk("vec_x_gain", (lx - ex < 1048576 && ex - lx < 1048576), 1);

    // Start while busy is ignored
    dc = done_cnt;
    launch(0, 64'h0000_7FFF_0000_1111, 64'h8000_0000_0000_0001,
           64'h1234_5678_9ABC_DEF0);
    repeat (4) @(negedge clk);
    mode = 1; x_in = 64'h5; y_in = 64'h6; z_in = 64'h7; start = 1;
    @(negedge clk);
    start = 0;
    repeat (44) @(negedge clk);
    mode = 0; x_in = 64'hAAAA; y_in = 64'hBBBB; z_in = 64'hCCCC; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(51, 200, c);
    chk("ign_latency", c, 97);
    repeat (5) @(negedge clk);
    chk("ign_one_done", done_cnt - dc, 1);

    // Reset mid-operation
    launch(1, 64'h0F00, 64'hFFFF_FFFF_FFFF_F000, 64'h77);
    repeat (39) @(negedge clk);
    reset = 1;
    void'(exp_q.pop_back());
    dc = done_cnt;
    @(negedge clk);
    reset = 0;
    chk("abort_clear", {busy, done, x_out, y_out, z_out}, '0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);
    launch(0, 64'h0200_0000_0000_0000, 64'h0100_0000_0000_0000,
           64'h0800_0000_0000_0000);
    wait_done(1, 200, c);
    chk("post_abort_latency", c, 97);

    // Start held high: back-to-back, inputs changed while busy
    @(negedge clk);
    drive_push(0, 64'h3333_0000_0000_0000, 64'hC000_0000_0000_0000,
               64'h0000_0000_0000_0000);
    start = 1;
    @(negedge clk);
    drive_push(1, 64'h0400_0000_0000_0000, 64'hFE00_0000_0000_0000,
               64'h0000_1000_0000_0000);
    wait_done(1, 200, c);
    chk("held_first", c, 97);
    @(negedge clk);
    chk("held_idle_gap", busy, 0);
    @(negedge clk);
    start = 0;
    chk("held_relaunch", busy, 1);
    wait_done(99, 400, c2);
    chk("held_throughput", c2 - c, 98);
    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
